// File: rtl/mem_access_arbiter_if.sv
// Byte-wide RAM/IO port plus the instruction-fetch and data-side request
// channels that mem_access_arbiter multiplexes onto it.
interface mem_access_arbiter_if;
  logic        flush_pipline;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ma_have_mem_access_task;
  logic [31:0] ma_mem_access_addr;
  logic        ma_mem_access_rw;
  logic [1:0]  ma_mem_access_size;
  logic [31:0] ma_mem_access_data;
  logic        ma_mem_access_task_done;
  logic [31:0] ma_mem_access_data_out;

  modport slave (
    input  flush_pipline, mem_din, io_buffer_full,
    input  if_req, if_addr,
    input  ma_have_mem_access_task, ma_mem_access_addr, ma_mem_access_rw,
    input  ma_mem_access_size, ma_mem_access_data,
    output mem_dout, mem_a, mem_wr,
    output if_done, if_data,
    output ma_mem_access_task_done, ma_mem_access_data_out
  );

  modport master (
    output flush_pipline, mem_din, io_buffer_full,
    output if_req, if_addr,
    output ma_have_mem_access_task, ma_mem_access_addr, ma_mem_access_rw,
    output ma_mem_access_size, ma_mem_access_data,
    input  mem_dout, mem_a, mem_wr,
    input  if_done, if_data,
    input  ma_mem_access_task_done, ma_mem_access_data_out
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Shares the byte-wide RAM/IO port between instruction fetch and the data
// side, splitting 1/2/4-byte accesses into little-endian byte cycles.
module mem_access_arbiter (
  input logic                 clk_in,
  input logic                 rst_in,
  input logic                 rdy_in,
  mem_access_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, COOL} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [31:0] base, base_nxt;
  logic [2:0]  len, len_nxt;
  logic        src_ma, src_ma_nxt;
  logic [31:0] wdata, wdata_nxt;
  logic [31:0] asm_q, asm_nxt;

  logic [31:0] mem_a_q, mem_a_nxt;
  logic [7:0]  mem_dout_q, mem_dout_nxt;
  logic        mem_wr_q, mem_wr_nxt;
  logic        if_done_q, if_done_nxt;
  logic [31:0] if_data_q, if_data_nxt;
  logic        ma_done_q, ma_done_nxt;
  logic [31:0] ma_data_q, ma_data_nxt;

  logic        io_blocked, take_ma, take_if;
  logic [2:0]  ma_len;
  logic [31:0] addr_k;
  logic [1:0]  rd_idx;

  // UART writes must wait for buffer room; fetch may use the port meanwhile
  assign io_blocked = bus.ma_mem_access_rw && bus.io_buffer_full &&
                      (bus.ma_mem_access_addr[17:16] == 2'b11);
  assign take_ma = (state == IDLE) && !bus.flush_pipline &&
                   bus.ma_have_mem_access_task && !io_blocked;
  assign take_if = (state == IDLE) && !bus.flush_pipline && !take_ma && bus.if_req;

  always_comb begin
    case (bus.ma_mem_access_size)
      2'b00:   ma_len = 3'd1;
      2'b01:   ma_len = 3'd2;
      default: ma_len = 3'd4;
    endcase
  end

  assign addr_k = base + {29'd0, cnt};
  // byte captured on the edge with counter value cnt belongs to lane cnt-2
  assign rd_idx = cnt[1:0] - 2'd2;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      base       <= 32'd0;
      len        <= 3'd0;
      src_ma     <= 1'b0;
      wdata      <= 32'd0;
      asm_q      <= 32'd0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      ma_done_q  <= 1'b0;
      ma_data_q  <= 32'd0;
    end else if (rdy_in) begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      base       <= base_nxt;
      len        <= len_nxt;
      src_ma     <= src_ma_nxt;
      wdata      <= wdata_nxt;
      asm_q      <= asm_nxt;
      mem_a_q    <= mem_a_nxt;
      mem_dout_q <= mem_dout_nxt;
      mem_wr_q   <= mem_wr_nxt;
      if_done_q  <= if_done_nxt;
      if_data_q  <= if_data_nxt;
      ma_done_q  <= ma_done_nxt;
      ma_data_q  <= ma_data_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    base_nxt   = base;
    len_nxt    = len;
    src_ma_nxt = src_ma;
    wdata_nxt  = wdata;
    case (state)
      IDLE: begin
        if (take_ma) begin
          state_nxt  = bus.ma_mem_access_rw ? WRITE : READ;
          cnt_nxt    = 3'd1;
          base_nxt   = bus.ma_mem_access_addr;
          len_nxt    = ma_len;
          src_ma_nxt = 1'b1;
          wdata_nxt  = bus.ma_mem_access_data;
        end else if (take_if) begin
          state_nxt  = READ;
          cnt_nxt    = 3'd1;
          base_nxt   = bus.if_addr;
          len_nxt    = 3'd4;
          src_ma_nxt = 1'b0;
        end
      end
      READ: begin
        if (bus.flush_pipline || (cnt == len + 3'd1)) begin
          state_nxt = COOL;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      WRITE: begin
        if (cnt == len) begin
          state_nxt = COOL;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      COOL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_a_nxt    = mem_a_q;
    mem_dout_nxt = mem_dout_q;
    mem_wr_nxt   = 1'b0;
    if_done_nxt  = 1'b0;
    ma_done_nxt  = 1'b0;
    if_data_nxt  = if_data_q;
    ma_data_nxt  = ma_data_q;
    asm_nxt      = asm_q;
    case (state)
      IDLE: begin
        if (take_ma) begin
          mem_a_nxt = bus.ma_mem_access_addr;
          asm_nxt   = 32'd0;
          if (bus.ma_mem_access_rw) begin
            mem_wr_nxt   = 1'b1;
            mem_dout_nxt = bus.ma_mem_access_data[7:0];
          end
        end else if (take_if) begin
          mem_a_nxt = bus.if_addr;
          asm_nxt   = 32'd0;
        end
      end
      READ: begin
        mem_a_nxt = (cnt < len) ? addr_k : 32'd0;
        if (bus.flush_pipline) begin
          mem_a_nxt = 32'd0;
        end else if (cnt >= 3'd2) begin
          asm_nxt[{rd_idx, 3'b000} +: 8] = bus.mem_din;
          if (cnt == len + 3'd1) begin
            if (src_ma) begin
              ma_done_nxt = 1'b1;
              ma_data_nxt = asm_nxt;
            end else begin
              if_done_nxt = 1'b1;
              if_data_nxt = asm_nxt;
            end
          end
        end
      end
      WRITE: begin
        if (cnt < len) begin
          mem_wr_nxt   = 1'b1;
          mem_a_nxt    = addr_k;
          mem_dout_nxt = wdata[{cnt[1:0], 3'b000} +: 8];
        end else begin
          mem_a_nxt = 32'd0;
          if (src_ma) ma_done_nxt = 1'b1;
          else        if_done_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_a                   = mem_a_q;
  assign bus.mem_dout                = mem_dout_q;
  assign bus.mem_wr                  = mem_wr_q;
  assign bus.if_done                 = if_done_q;
  assign bus.if_data                 = if_data_q;
  assign bus.ma_mem_access_task_done = ma_done_q;
  assign bus.ma_mem_access_data_out  = ma_data_q;
endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

- Sequences all traffic on the single byte-wide RAM/IO port and shares it between two requesters: instruction fetch, and the data side driven by the memory operator's `ma_*` task interface.
- Splits each 1/2/4-byte access into consecutive byte cycles with little-endian assembly.
- Arbitrates data-over-fetch, honours `io_buffer_full` for IO writes, and aborts in-flight reads on `flush_pipline`.

## Interface
- No parameters.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: when low, every register holds its value.
- `flush_pipline` in 1: abort in-flight reads and block acceptance this cycle.
- `mem_din` in 8: RAM read byte. Valid one cycle after its address is registered.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out 32: RAM address, registered.
- `mem_wr` out 1: 1 = write, registered.
- `io_buffer_full` in 1: UART buffer full.
- `if_req` in 1: fetch request. Level signal, held until `if_done`.
- `if_addr` in 32: fetch address.
- `if_done` out 1: one-cycle pulse.
- `if_data` out 32: fetched word. Valid while `if_done` is high.
- `ma_have_mem_access_task` in 1: data request. Level signal, held until done.
- `ma_mem_access_addr` in 32: data address.
- `ma_mem_access_rw` in 1: 0 = read, 1 = write.
- `ma_mem_access_size` in 2: 00 = 1 byte, 01 = 2 bytes, 10 and 11 = 4 bytes.
- `ma_mem_access_data` in 32: store data; the low `size` bytes are written.
- `ma_mem_access_task_done` out 1: one-cycle pulse.
- `ma_mem_access_data_out` out 32: load bytes, zero-filled above size. Valid with done.

## Operation
- States: IDLE, READ, WRITE, COOL. 3-bit byte counter; latched base address, length N, source, store data; 32-bit assembly register.
- Reset: state IDLE, counters 0.
  - Outputs: `mem_a`=0, `mem_dout`=0, `mem_wr`=0, `if_done`=0, `ma_mem_access_task_done`=0, `if_data`=0, `ma_mem_access_data_out`=0.
- IDLE accept, evaluated at each edge with `rdy_in`=1 and `flush_pipline`=0:
  - Data request wins over `if_req`.
  - A data write is blocked while `io_buffer_full`=1 and `ma_mem_access_addr[17:16]`==2'b11. In that case `if_req`, if present, is accepted instead.
  - Fetch N is always 4.
- Accept edge:
  - Latch the request.
  - Set `mem_a` = base.
  - READ: `mem_wr`=0.
  - WRITE: `mem_wr`=1 and `mem_dout` = byte 0.
- READ:
  - Each following edge registers `mem_a` = base+k for k=1..N-1, then `mem_a`=0.
  - Byte k is captured from `mem_din` into bits [8k+7:8k] at the (k+2)-th edge after accept.
  - The edge capturing byte N-1 pulses the selected done and presents the data, then enters COOL.
- WRITE:
  - Edge k after accept (k=1..N-1) drives `mem_a`=base+k and `mem_dout`=byte k.
  - Edge N drives `mem_wr`=0, `mem_a`=0, pulses done, then enters COOL.
- COOL: exactly one cycle with no acceptance, so the requester can drop its level request after done; then IDLE.
- Flush:
  - In READ (either source): the next edge goes to COOL with no done pulse, `mem_a`=0. This also applies on the final capture edge.
  - In WRITE: ignored; the write completes and done still pulses.
- Address arithmetic is 32-bit modulo 2^32, so base+k wraps from 0xFFFFFFFF to 0.
- Done pulses are high exactly one cycle; `if_data` and `ma_mem_access_data_out` hold their values afterwards.

## Timing
- Request high in cycle t while IDLE:
  - Read of N bytes: done high in cycle t+N+2 (lb t+3, lh t+4, lw/fetch t+6).
  - Write of N bytes: done high in cycle t+N+1.
  - Next request can be accepted at the edge ending cycle (done cycle)+1, i.e. after COOL.
- `mem_wr` is never high in READ, COOL or IDLE.
- `rdy_in` low freezes state, counters and outputs, including a pending done pulse, which is re-presented when `rdy_in` returns high.
- Reset asserted mid-transaction: at the next edge, IDLE with all outputs at their reset values. No done pulse.

## Test plan
- Fetch:
  - Stimulus: RAM bytes 0x13,0x05,0x10,0x00 at 0x100; `if_req`=1, `if_addr`=0x100 in cycle 0.
  - Response: `mem_a` 0x100..0x103 on consecutive cycles; `if_done` only in cycle 6 with `if_data`=0x00100513.
- Contention:
  - Stimulus: `if_req` and a data lb at 0x200 (byte 0x80) both asserted in cycle 0.
  - Response: data served first; done in cycle 3 with data_out=0x00000080. Fetch accepted after COOL.
- Store halfword:
  - Stimulus: sh, data 0xAABBCCDD to 0x300.
  - Response: writes 0xDD@0x300 then 0xCC@0x301; `mem_wr` high exactly 2 cycles; done in cycle 3.
- IO backpressure:
  - Stimulus: sb to 0x30000 with `io_buffer_full`=1 for 5 cycles, `if_req` also high.
  - Response: fetch proceeds and completes; store accepted only after `io_buffer_full` falls.
- Flush:
  - Stimulus: `flush_pipline` during an lw at byte 2.
  - Response: no done pulse; IDLE two cycles later.
  - Stimulus: `flush_pipline` during an sw.
  - Response: all 4 bytes written; done pulses.
- Reset and stall:
  - Stimulus: `rst_in` mid-write.
  - Response: `mem_wr`=0 next cycle.
  - Stimulus: `rdy_in` low for 3 cycles during a read.
  - Response: latency extended by exactly 3 cycles; data correct.
